// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/WAIT/HOLD sequencer between the control FSM, instruction memory and decode.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the misaligned-PC fault path (no memory request for misaligned PCs).
module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        fetch_start,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        fetch_busy,
    output logic        fault_access,
    output logic        fault_misalign
);

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC      = 32'h8000_0000;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] ir_pc_reg, ir_pc_next;
    logic [31:0] ir_out_reg, ir_out_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        fault_access_reg, fault_access_next;
    logic        launch;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault_misalign_reg, fault_misalign_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= RESET_PC;
            ir_pc_reg        <= RESET_PC;
            ir_out_reg       <= NOP_INSTR;
            cnt_reg          <= 8'd0;
            fault_access_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            ir_pc_reg        <= ir_pc_next;
            ir_out_reg       <= ir_out_next;
            cnt_reg          <= cnt_next;
            fault_access_reg <= fault_access_next;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_misalign_reg <= 1'b0;
        end else begin
            fault_misalign_reg <= fault_misalign_next;
        end
    end
`endif

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        ir_pc_next        = ir_pc_reg;
        ir_out_next       = ir_out_reg;
        cnt_next          = cnt_reg;
        fault_access_next = fault_access_reg;
        launch            = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_misalign_next = fault_misalign_reg;
`endif

        case (state_reg)
            IDLE: begin
                launch = fetch_start;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_next = WAIT;
                    cnt_next   = 8'd0;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_next        = HOLD;
                    ir_out_next       = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
                    fault_access_next = imem_rsp_err;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    // Timeout fires on the cycle the counter would reach the limit.
                    if (cnt_reg + 8'd1 == TIMEOUT_LIMIT) begin
                        state_next        = HOLD;
                        ir_out_next       = NOP_INSTR;
                        fault_access_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    state_next        = IDLE;
                    fault_access_next = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                    fault_misalign_next = 1'b0;
`endif
                    launch = fetch_start;
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            addr_next  = pc_in;
            ir_pc_next = pc_in;
            state_next = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
            // Misaligned PC bypasses memory entirely and reports a fault as the fetched word.
            if (pc_in[1:0] != 2'b00) begin
                state_next          = HOLD;
                ir_out_next         = NOP_INSTR;
                fault_misalign_next = 1'b1;
            end
`endif
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = addr_reg;
    assign ir_valid       = (state_reg == HOLD);
    assign ir_out         = ir_out_reg;
    assign ir_pc          = ir_pc_reg;
    assign fetch_busy     = (state_reg != IDLE);
    assign fault_access   = fault_access_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fault_misalign = fault_misalign_reg;
`else
    assign fault_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch (TIMEOUT_CYCLES=4); one line per transaction plus a summary.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        fetch_busy;
    logic        fault_access;
    logic        fault_misalign;

    int check_count = 0;
    int error_count = 0;

    instr_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .fetch_start    (fetch_start),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_out         (ir_out),
        .ir_pc          (ir_pc),
        .fetch_busy     (fetch_busy),
        .fault_access   (fault_access),
        .fault_misalign (fault_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0; fetch_start = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; ir_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir_out", ir_out, 32'h0000_0013);
        check("rst_ir_pc", ir_pc, 32'h8000_0000);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_faults", {30'd0, fault_access, fault_misalign}, 32'd0);
        $display("reset: busy=%0d ir_out=%08h", fetch_busy, ir_out);

        // Minimum-latency fetch: ir_valid three edges after fetch_start.
        pc_in = 32'h8000_0000; fetch_start = 1'b1; imem_req_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        imem_req_ready = 1'b0;
        check("t1_wait_req_low", 32'(imem_req_valid), 32'd0);
        check("t1_wait_busy", 32'(fetch_busy), 32'd1);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
        tick();
        imem_rsp_valid = 1'b0;
        check("t1_ir_valid", 32'(ir_valid), 32'd1);
        check("t1_ir_out", ir_out, 32'h0000_0093);
        check("t1_ir_pc", ir_pc, 32'h8000_0000);
        check("t1_fault", 32'(fault_access), 32'd0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("t1_after_hs_valid", 32'(ir_valid), 32'd0);
        check("t1_after_hs_ir", ir_out, 32'h0000_0093);
        check("t1_after_hs_busy", 32'(fetch_busy), 32'd0);
        $display("fetch pc=%08h ir=%08h", ir_pc, ir_out);

        // Stalled request, then error response.
        pc_in = 32'h8000_0010; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0; pc_in = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", 32'(imem_req_valid), 32'd1);
            check("t2_stall_addr", imem_req_addr, 32'h8000_0010);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hffff_ffff;
        tick();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        check("t2_ir_valid", 32'(ir_valid), 32'd1);
        check("t2_ir_out", ir_out, 32'h0000_0013);
        check("t2_fault_access", 32'(fault_access), 32'd1);
        check("t2_fault_misalign", 32'(fault_misalign), 32'd0);
        check("t2_ir_pc", ir_pc, 32'h8000_0010);
        // fetch_start in HOLD without ir_ready is ignored.
        pc_in = 32'h8000_0040; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("t2_hold_ignore_valid", 32'(ir_valid), 32'd1);
        check("t2_hold_ignore_req", 32'(imem_req_valid), 32'd0);
        check("t2_hold_ignore_pc", ir_pc, 32'h8000_0010);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("t2_fault_cleared", 32'(fault_access), 32'd0);
        $display("fetch pc=%08h access fault handled", ir_pc);

        // Timeout: four WAIT cycles with no response.
        pc_in = 32'h8000_0020; fetch_start = 1'b1; imem_req_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        tick(); tick(); tick();
        check("t3_before_timeout", 32'(ir_valid), 32'd0);
        tick();
        check("t3_timeout_valid", 32'(ir_valid), 32'd1);
        check("t3_timeout_fault", 32'(fault_access), 32'd1);
        check("t3_timeout_ir", ir_out, 32'h0000_0013);
        // Response in HOLD is ignored.
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0055;
        tick();
        imem_rsp_valid = 1'b0;
        check("t3_hold_rsp_ignored", ir_out, 32'h0000_0013);
        $display("fetch pc=%08h timeout fault", ir_pc);

        // Back-to-back: handshake and new fetch_start in the same HOLD cycle.
        ir_ready = 1'b1; fetch_start = 1'b1; pc_in = 32'h8000_0004;
        tick();
        ir_ready = 1'b0; fetch_start = 1'b0;
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h8000_0004);
        check("t4_ir_valid", 32'(ir_valid), 32'd0);
        check("t4_fault_cleared", 32'(fault_access), 32'd0);
        check("t4_ir_pc", ir_pc, 32'h8000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0113;
        tick();
        imem_rsp_valid = 1'b0;
        check("t4_ir_out", ir_out, 32'h0000_0113);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        $display("fetch pc=%08h ir=%08h back-to-back", ir_pc, ir_out);

        // Reset during WAIT; the late response must be ignored.
        pc_in = 32'h8000_0008; fetch_start = 1'b1; imem_req_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0777;
        tick();
        imem_rsp_valid = 1'b0;
        check("t5_busy", 32'(fetch_busy), 32'd0);
        check("t5_ir_valid", 32'(ir_valid), 32'd0);
        check("t5_ir_out", ir_out, 32'h0000_0013);
        check("t5_ir_pc", ir_pc, 32'h8000_0000);
        $display("reset mid-fetch: busy=%0d ir_out=%08h", fetch_busy, ir_out);

        // Misaligned PC.
        pc_in = 32'h8000_0002; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_no_req", 32'(imem_req_valid), 32'd0);
        check("t6_ir_valid", 32'(ir_valid), 32'd1);
        check("t6_fault_misalign", 32'(fault_misalign), 32'd1);
        check("t6_fault_access", 32'(fault_access), 32'd0);
        check("t6_ir_out", ir_out, 32'h0000_0013);
        check("t6_ir_pc", ir_pc, 32'h8000_0002);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("t6_misalign_cleared", 32'(fault_misalign), 32'd0);
`else
        check("t6_req_valid", 32'(imem_req_valid), 32'd1);
        check("t6_req_addr", imem_req_addr, 32'h8000_0002);
        check("t6_fault_misalign", 32'(fault_misalign), 32'd0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0213;
        tick();
        imem_rsp_valid = 1'b0;
        check("t6_ir_out", ir_out, 32'h0000_0213);
        check("t6_ir_pc", ir_pc, 32'h8000_0002);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
`endif
        $display("fetch pc=%08h ir=%08h misalign=%0d", ir_pc, ir_out, fault_misalign);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
